osc_tick_gen: RTL and testbench

//  Consumer of the on-chip oscillator output (GW1N-4, 210 MHz / FREQ_DIV=2 = 105 MHz).

---
 rtl/osc_tick_gen_pkg.sv | 23 ++
 rtl/osc_tick_gen_mod_n_cnt.sv | 33 +++
 rtl/osc_tick_gen.sv | 159 +++++++++++++++
 tb/tb_osc_tick_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/osc_tick_gen_pkg.sv
// Shared definitions for the oscillator timebase: default parameters,
// FSM state encoding and a counter-width helper.
package osc_tick_gen_pkg;

  // 210 MHz oscillator divided by 2 on the GW1N-4.
  localparam int unsigned CLK_HZ_DEFAULT        = 105_000_000;
  localparam int unsigned RST_HOLD_CYC_DEFAULT  = 1024;
  localparam int unsigned BLINK_HALF_MS_DEFAULT = 500;
  localparam int unsigned US_PER_MS_DEFAULT     = 1000;
  localparam int unsigned MS_PER_S_DEFAULT      = 1000;

  // HOLD keeps downstream logic in reset; RUN is terminal until sys_rst_n drops.
  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } osc_state_e;

  // Bits needed to count 0..n-1; a modulo-1 counter still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/osc_tick_gen_mod_n_cnt.sv
// Modulo-N enable counter. wrap is combinational and only asserts on an
// enabled cycle at N-1, so chaining wrap into the next stage's en gives a
// cascade whose carries all line up in the same cycle.
module mod_n_cnt
  import osc_tick_gen_pkg::*;
#(
  parameter int unsigned N = 10,
  localparam int unsigned W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;

  assign wrap = en && (r_cnt == LAST);
  assign cnt  = r_cnt;

  // Advance on enable, returning to zero after N-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/osc_tick_gen.sv
// Oscillator timebase: stretches sys_rst_n into rst_out_n, then produces
// 1 us / 1 ms / 1 s single-cycle strobes, a seconds uptime counter and a
// heartbeat LED. CLK_HZ must be an integer multiple of 1 MHz.
//
// Handshake: there is none; tick_en is a level-sensitive run/pause qualifier
// sampled every edge. A cycle with tick_en=0 freezes every counter and
// produces no strobe, so a pending strobe simply lands after the pause.
module osc_tick_gen
  import osc_tick_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ        = CLK_HZ_DEFAULT,
  parameter int unsigned RST_HOLD_CYC  = RST_HOLD_CYC_DEFAULT,
  parameter int unsigned BLINK_HALF_MS = BLINK_HALF_MS_DEFAULT,
  parameter int unsigned US_PER_MS     = US_PER_MS_DEFAULT,
  parameter int unsigned MS_PER_S      = MS_PER_S_DEFAULT,
  parameter logic [31:0] UPTIME_INIT   = 32'd0,
  localparam int unsigned US_DIV       = CLK_HZ / 1_000_000,
  localparam int unsigned US_W         = cnt_width(US_DIV),
  localparam int unsigned MS_W         = cnt_width(US_PER_MS),
  localparam int unsigned S_W          = cnt_width(MS_PER_S),
  localparam int unsigned BL_W         = cnt_width(BLINK_HALF_MS)
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            tick_en,
  output logic            rst_out_n,
  output logic            tick_us,
  output logic            tick_ms,
  output logic            tick_s,
  output logic [31:0]     uptime_s,
  output logic            led,
  output osc_state_e      o_dbg_state,
  output logic [US_W-1:0] o_dbg_us_cnt,
  output logic [MS_W-1:0] o_dbg_ms_cnt,
  output logic [S_W-1:0]  o_dbg_s_cnt,
  output logic [BL_W-1:0] o_dbg_blink_cnt
);

  localparam int unsigned       HOLD_W    = cnt_width(RST_HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);

  osc_state_e        r_state;
  osc_state_e        w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;

  logic w_run_en;
  logic w_us_wrap;
  logic w_ms_wrap;
  logic w_s_wrap;
  logic w_blink_wrap;

  logic        r_rst_out_n;
  logic        r_tick_us;
  logic        r_tick_ms;
  logic        r_tick_s;
  logic [31:0] r_uptime;
  logic        r_led;

  // State and hold-counter registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // HOLD counts RST_HOLD_CYC cycles then moves to RUN for good.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    unique case (r_state)
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_HOLD;
      end
    endcase
  end

  // tick_en only matters once the hold phase is over.
  assign w_run_en = (r_state == ST_RUN) && tick_en;

  mod_n_cnt #(.N(US_DIV)) u_us_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (w_run_en),
    .cnt   (o_dbg_us_cnt),
    .wrap  (w_us_wrap)
  );

  mod_n_cnt #(.N(US_PER_MS)) u_ms_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (w_us_wrap),
    .cnt   (o_dbg_ms_cnt),
    .wrap  (w_ms_wrap)
  );

  mod_n_cnt #(.N(MS_PER_S)) u_s_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (w_ms_wrap),
    .cnt   (o_dbg_s_cnt),
    .wrap  (w_s_wrap)
  );

  mod_n_cnt #(.N(BLINK_HALF_MS)) u_blink_cnt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (w_ms_wrap),
    .cnt   (o_dbg_blink_cnt),
    .wrap  (w_blink_wrap)
  );

  // Output registers: every strobe is the registered wrap of its chain stage,
  // so coincident boundaries appear together one cycle after the wrap.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rst_out_n <= 1'b0;
      r_tick_us   <= 1'b0;
      r_tick_ms   <= 1'b0;
      r_tick_s    <= 1'b0;
      r_uptime    <= UPTIME_INIT;
      r_led       <= 1'b0;
    end else begin
      r_rst_out_n <= (r_state == ST_RUN);
      r_tick_us   <= w_us_wrap;
      r_tick_ms   <= w_ms_wrap;
      r_tick_s    <= w_s_wrap;
      if (w_s_wrap) begin
        r_uptime <= r_uptime + 32'd1;
      end
      if (w_blink_wrap) begin
        r_led <= ~r_led;
      end
    end
  end

  assign rst_out_n   = r_rst_out_n;
  assign tick_us     = r_tick_us;
  assign tick_ms     = r_tick_ms;
  assign tick_s      = r_tick_s;
  assign uptime_s    = r_uptime;
  assign led         = r_led;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_osc_tick_gen.sv
// Directed bench for osc_tick_gen at CLK_HZ=10 MHz, RST_HOLD_CYC=8,
// BLINK_HALF_MS=2. dut_a keeps the full 1000/1000 chains for us/ms/led
// timing; dut_b and dut_c shorten the ms and s chains (4 us/ms, 5 ms/s)
// so whole seconds fit in the run, and dut_c starts uptime at 0xFFFF_FFFF.
module tb_osc_tick_gen;
  import osc_tick_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // dut_a signals
  logic rst_a_n, en_a;
  logic rst_out_a, tick_us_a, tick_ms_a, tick_s_a, led_a;
  logic [31:0] uptime_a;
  osc_state_e state_a;
  logic [cnt_width(10)-1:0]   us_cnt_a;
  logic [cnt_width(1000)-1:0] ms_cnt_a;
  logic [cnt_width(1000)-1:0] s_cnt_a;
  logic [cnt_width(2)-1:0]    bl_cnt_a;

  // dut_b / dut_c share stimulus
  logic rst_b_n, en_b;
  logic rst_out_b, tick_us_b, tick_ms_b, tick_s_b, led_b;
  logic [31:0] uptime_b;
  osc_state_e state_b;
  logic [cnt_width(10)-1:0] us_cnt_b;
  logic [cnt_width(4)-1:0]  ms_cnt_b;
  logic [cnt_width(5)-1:0]  s_cnt_b;
  logic [cnt_width(2)-1:0]  bl_cnt_b;

  logic rst_out_c, tick_us_c, tick_ms_c, tick_s_c, led_c;
  logic [31:0] uptime_c;
  osc_state_e state_c;
  logic [cnt_width(10)-1:0] us_cnt_c;
  logic [cnt_width(4)-1:0]  ms_cnt_c;
  logic [cnt_width(5)-1:0]  s_cnt_c;
  logic [cnt_width(2)-1:0]  bl_cnt_c;

  osc_tick_gen #(
    .CLK_HZ(10_000_000), .RST_HOLD_CYC(8), .BLINK_HALF_MS(2)
  ) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_a_n), .tick_en(en_a),
    .rst_out_n(rst_out_a), .tick_us(tick_us_a), .tick_ms(tick_ms_a),
    .tick_s(tick_s_a), .uptime_s(uptime_a), .led(led_a),
    .o_dbg_state(state_a), .o_dbg_us_cnt(us_cnt_a), .o_dbg_ms_cnt(ms_cnt_a),
    .o_dbg_s_cnt(s_cnt_a), .o_dbg_blink_cnt(bl_cnt_a)
  );

  osc_tick_gen #(
    .CLK_HZ(10_000_000), .RST_HOLD_CYC(8), .BLINK_HALF_MS(2),
    .US_PER_MS(4), .MS_PER_S(5)
  ) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_b_n), .tick_en(en_b),
    .rst_out_n(rst_out_b), .tick_us(tick_us_b), .tick_ms(tick_ms_b),
    .tick_s(tick_s_b), .uptime_s(uptime_b), .led(led_b),
    .o_dbg_state(state_b), .o_dbg_us_cnt(us_cnt_b), .o_dbg_ms_cnt(ms_cnt_b),
    .o_dbg_s_cnt(s_cnt_b), .o_dbg_blink_cnt(bl_cnt_b)
  );

  osc_tick_gen #(
    .CLK_HZ(10_000_000), .RST_HOLD_CYC(8), .BLINK_HALF_MS(2),
    .US_PER_MS(4), .MS_PER_S(5), .UPTIME_INIT(32'hFFFF_FFFF)
  ) dut_c (
    .sys_clk(clk), .sys_rst_n(rst_b_n), .tick_en(en_b),
    .rst_out_n(rst_out_c), .tick_us(tick_us_c), .tick_ms(tick_ms_c),
    .tick_s(tick_s_c), .uptime_s(uptime_c), .led(led_c),
    .o_dbg_state(state_c), .o_dbg_us_cnt(us_cnt_c), .o_dbg_ms_cnt(ms_cnt_c),
    .o_dbg_s_cnt(s_cnt_c), .o_dbg_blink_cnt(bl_cnt_c)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Count cycles until the selected strobe is seen (0=a.tick_us, 1=a.tick_ms).
  task automatic wait_strobe(input int sel, input int budget, output int cyc);
    logic hit;
    cyc = 0;
    do begin
      step();
      cyc++;
      hit = (sel == 0) ? tick_us_a : tick_ms_a;
    end while (hit !== 1'b1 && cyc < budget);
  endtask

  // Expected dut_b/dut_c outputs at sample k after release, tick_en held 1.
  task automatic check_b_cycle(input int k, input logic [31:0] c_init);
    int secs, toggles;
    secs    = (k >= 208) ? (k - 208) / 200 + 1 : 0;
    toggles = (k >= 88)  ? (k - 88) / 80 + 1   : 0;
    chk("b_rst_out", 32'(rst_out_b), 32'(k >= 9));
    chk("b_state",   32'(state_b),   32'((k >= 8) ? ST_RUN : ST_HOLD));
    chk("b_tick_us", 32'(tick_us_b), 32'(k >= 18 && (k - 18) % 10 == 0));
    chk("b_tick_ms", 32'(tick_ms_b), 32'(k >= 48 && (k - 48) % 40 == 0));
    chk("b_tick_s",  32'(tick_s_b),  32'(k >= 208 && (k - 208) % 200 == 0));
    chk("b_uptime",  uptime_b,       32'(secs));
    chk("b_led",     32'(led_b),     32'(toggles % 2));
    chk("c_uptime",  uptime_c,       c_init + 32'(secs));
    chk("c_tick_s",  32'(tick_s_c),  32'(k >= 208 && (k - 208) % 200 == 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_a_n = 1'b0; en_a = 1'b0;
    rst_b_n = 1'b0; en_b = 1'b0;
    repeat (3) step();

    // Reset state
    chk("a_rst_out_rst", 32'(rst_out_a), 32'd0);
    chk("a_ticks_rst",   32'({tick_us_a, tick_ms_a, tick_s_a}), 32'd0);
    chk("a_uptime_rst",  uptime_a, 32'd0);
    chk("a_led_rst",     32'(led_a), 32'd0);
    chk("a_state_rst",   32'(state_a), 32'(ST_HOLD));
    chk("a_cnts_rst",    32'({us_cnt_a, ms_cnt_a, s_cnt_a, bl_cnt_a}), 32'd0);
    chk("b_uptime_rst",  uptime_b, 32'd0);
    chk("c_uptime_rst",  uptime_c, 32'hFFFF_FFFF);

    // Release with tick_en already high: 8-cycle hold, then first tick_us.
    rst_a_n = 1'b1; en_a = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("a_rst_out_hold", 32'(rst_out_a), 32'(k >= 9));
      chk("a_state_hold",   32'(state_a),   32'((k >= 8) ? ST_RUN : ST_HOLD));
      chk("a_tick_us_first", 32'(tick_us_a), 32'(k == 18));
      chk("a_us_cnt",       32'(us_cnt_a),  32'((k >= 8) ? (k - 8) % 10 : 0));
      chk("a_led_hold",     32'(led_a),     32'd0);
    end

    // tick_us period
    for (int i = 0; i < 3; i++) begin
      wait_strobe(0, 50, cyc);
      chk("a_us_period", 32'(cyc), 32'd10);
    end

    // tick_ms: 1000th tick_us lands at sample 10008; we stand at sample 48.
    wait_strobe(1, 20000, cyc);
    chk("a_ms_first", 32'(cyc), 32'd9960);
    chk("a_ms_us_coinc", 32'(tick_us_a), 32'd1);
    chk("a_led_1ms", 32'(led_a), 32'd0);
    wait_strobe(1, 20000, cyc);
    chk("a_ms_period", 32'(cyc), 32'd10000);
    chk("a_led_2ms", 32'(led_a), 32'd1);
    chk("a_no_s", 32'(tick_s_a), 32'd0);
    wait_strobe(1, 20000, cyc);
    chk("a_ms_period", 32'(cyc), 32'd10000);
    chk("a_led_3ms", 32'(led_a), 32'd1);
    wait_strobe(1, 20000, cyc);
    chk("a_ms_period", 32'(cyc), 32'd10000);
    chk("a_led_4ms", 32'(led_a), 32'd0);
    chk("a_ms_us_coinc4", 32'(tick_us_a), 32'd1);

    // Pause 7 cycles once the us counter reaches 5: next tick_us 17 cycles later.
    for (int j = 1; j <= 17; j++) begin
      step();
      chk("a_pause_tick_us", 32'(tick_us_a), 32'(j == 17));
      if (j == 5)  chk("a_pause_cnt5",  32'(us_cnt_a), 32'd5);
      if (j == 12) chk("a_pause_held",  32'(us_cnt_a), 32'd5);
      if (j == 5)  en_a = 1'b0;
      if (j == 12) en_a = 1'b1;
    end
    wait_strobe(0, 50, cyc);
    chk("a_us_after_pause", 32'(cyc), 32'd10);

    // tick_en toggled every cycle: period doubles to 20.
    en_a = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("a_toggle_tick_us", 32'(tick_us_a), 32'(j == 20));
      en_a = ~en_a;
    end
    en_a = 1'b1;

    // Mid-operation reset of dut_a.
    rst_a_n = 1'b0;
    step();
    chk("a_midrst_rst_out", 32'(rst_out_a), 32'd0);
    chk("a_midrst_ticks",   32'({tick_us_a, tick_ms_a, tick_s_a}), 32'd0);
    chk("a_midrst_led",     32'(led_a), 32'd0);
    chk("a_midrst_state",   32'(state_a), 32'(ST_HOLD));
    chk("a_midrst_cnts",    32'({us_cnt_a, ms_cnt_a, s_cnt_a, bl_cnt_a}), 32'd0);

    // Short chains: seconds, coincidence, uptime wrap on dut_c.
    rst_b_n = 1'b1; en_b = 1'b1;
    for (int k = 1; k <= 458; k++) begin
      step();
      check_b_cycle(k, 32'hFFFF_FFFF);
      if (k == 208) begin
        chk("b_triple_coinc", 32'({tick_us_b, tick_ms_b, tick_s_b}), 32'b111);
        chk("c_wrap_zero", uptime_c, 32'd0);
      end
    end

    // Reset mid-second (uptime_s=2): everything restarts from zero.
    rst_b_n = 1'b0;
    step();
    chk("b_midrst_rst_out", 32'(rst_out_b), 32'd0);
    chk("b_midrst_ticks",   32'({tick_us_b, tick_ms_b, tick_s_b}), 32'd0);
    chk("b_midrst_uptime",  uptime_b, 32'd0);
    chk("b_midrst_led",     32'(led_b), 32'd0);
    chk("b_midrst_state",   32'(state_b), 32'(ST_HOLD));
    chk("b_midrst_cnts",    32'({us_cnt_b, ms_cnt_b, s_cnt_b, bl_cnt_b}), 32'd0);
    rst_b_n = 1'b1;
    for (int k = 1; k <= 608; k++) begin
      step();
      check_b_cycle(k, 32'hFFFF_FFFF);
    end
    chk("b_uptime_3s", uptime_b, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
